// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared, registered ALU: round-robin grant,
// one operation in flight, illegal/divide-by-zero rejection and a held response.
module alu_arbiter #(
  parameter int DW = 16,
  parameter int FW = 4
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic [FW-1:0] req0_fun,

  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  input  logic [FW-1:0] req1_fun,

  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [FW-1:0] alu_fun,
  input  logic [DW-1:0] alu_out,
  input  logic [3:0]    alu_flags,

  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [DW-1:0] rsp_data,
  output logic [3:0]    rsp_flags,
  output logic          rsp_err
);

  localparam logic [FW-1:0] FUN_NOP = '1;
  localparam logic [FW-1:0] FUN_DIV = FW'(3);

  typedef enum logic [1:0] {IDLE, EXEC, WAIT, RESP} state_t;

  state_t        state;
  logic          rr;          // requester that wins the next conflict
  logic          acc;
  logic          acc_id;
  logic          acc_reject;
  logic [DW-1:0] acc_a;
  logic [DW-1:0] acc_b;
  logic [FW-1:0] acc_fun;

  // NOTE: every output of an always_comb gets a default first, so no path
  // through the block can leave a value unassigned and infer a latch.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!rst && state == IDLE) begin
      if (req0_valid && req1_valid) begin
        req0_ready = !rr;
        req1_ready = rr;
      end else begin
        req0_ready = req0_valid;
        req1_ready = req1_valid;
      end
    end
  end

  assign acc        = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign acc_id     = req1_ready;
  assign acc_a      = acc_id ? req1_a   : req0_a;
  assign acc_b      = acc_id ? req1_b   : req0_b;
  assign acc_fun    = acc_id ? req1_fun : req0_fun;
  assign acc_reject = (acc_fun == FUN_NOP) || ((acc_fun == FUN_DIV) && (acc_b == '0));

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr        <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_fun   <= FUN_NOP;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      rsp_flags <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (acc) begin
            rr     <= !acc_id;
            rsp_id <= acc_id;
            if (acc_reject) begin
              rsp_data  <= '0;
              rsp_flags <= '0;
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              alu_a   <= acc_a;
              alu_b   <= acc_b;
              alu_fun <= acc_fun;
              rsp_err <= 1'b0;
              state   <= EXEC;
            end
          end
        end
        EXEC: begin
          rsp_flags <= alu_flags;
          state     <= WAIT;
        end
        WAIT: begin
          // The ALU registered its result at the end of EXEC; release it afterwards.
          rsp_data  <= alu_out;
          rsp_valid <= 1'b1;
          alu_a     <= '0;
          alu_b     <= '0;
          alu_fun   <= FUN_NOP;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU, transaction-level reference model,
// directed scenarios followed by randomized traffic with occasional resets.
module tb_alu_arbiter;

  localparam int DW = 16;
  localparam int FW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [FW-1:0] req0_fun, req1_fun;
  logic [DW-1:0] alu_a, alu_b, alu_out;
  logic [FW-1:0] alu_fun;
  logic [3:0]    alu_flags;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [DW-1:0] rsp_data;
  logic [3:0]    rsp_flags;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DW(DW), .FW(FW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_fun(req0_fun),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_fun(req1_fun),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun),
    .alu_out(alu_out), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags), .rsp_err(rsp_err)
  );

  // Shared ALU: registered result, combinational class flags {ARITH,LOGIC,CMP,SHIFT}.
  function automatic logic [DW-1:0] alu_calc(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [FW-1:0] f);
    case (f)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a * b;
      4'h3: return (b == 0) ? '1 : a / b;
      4'h4: return a & b;
      4'h5: return a | b;
      4'h6: return a ^ b;
      4'h7: return ~a;
      4'h8: return DW'(a < b);
      4'h9: return DW'(a > b);
      4'hA: return DW'(a == b);
      4'hB: return DW'(a != b);
      4'hC: return a >> b[3:0];
      4'hD: return DW'($signed(a) >>> b[3:0]);
      4'hE: return a << b[3:0];
      default: return '0;
    endcase
  endfunction

  function automatic logic [3:0] alu_class(input logic [FW-1:0] f);
    if (f < 4)       return 4'b1000;
    else if (f < 8)  return 4'b0100;
    else if (f < 12) return 4'b0010;
    else if (f < 15) return 4'b0001;
    else             return 4'b0000;
  endfunction

  always @(posedge clk) alu_out <= alu_calc(alu_a, alu_b, alu_fun);
  assign alu_flags = alu_class(alu_fun);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic          id;
    logic [DW-1:0] data;
    logic [3:0]    flags;
    logic          err;
    int            lat;
  } rsp_t;

  rsp_t rsp_q[$];
  int   grant_q[$];

  // Reference model: one operation outstanding, priority pointer, due cycle.
  bit            m_busy = 0, m_rr = 0, m_id, m_err, m_legal;
  logic [DW-1:0] m_a, m_b, m_data;
  logic [FW-1:0] m_fun;
  logic [3:0]    m_flags;
  int            m_due, m_acc, v_first;

  task automatic observe();
    int g;
    bit exp_v;
    @(negedge clk);
    if (rst) begin
      check("rst_ready0", req0_ready, 0);
      check("rst_ready1", req1_ready, 0);
      m_busy = 0;
      m_rr   = 0;
    end else begin
      g = -1;
      if (!m_busy) begin
        if (req0_valid && req1_valid) g = m_rr ? 1 : 0;
        else if (req0_valid)          g = 0;
        else if (req1_valid)          g = 1;
      end
      check("ready0", req0_ready, 32'(g == 0));
      check("ready1", req1_ready, 32'(g == 1));
      exp_v = m_busy && (cyc >= m_due);
      check("rsp_valid", rsp_valid, 32'(exp_v));
      if (exp_v) begin
        check("rsp_id", rsp_id, m_id);
        check("rsp_data", rsp_data, m_data);
        check("rsp_flags", rsp_flags, m_flags);
        check("rsp_err", rsp_err, m_err);
      end
      if (m_busy && m_legal && cyc < m_due) begin
        check("alu_a_op", alu_a, m_a);
        check("alu_b_op", alu_b, m_b);
        check("alu_fun_op", alu_fun, m_fun);
      end else if (!m_busy || !m_legal) begin
        check("alu_fun_idle", alu_fun, 4'hF);
        check("alu_a_idle", alu_a, 0);
        check("alu_b_idle", alu_b, 0);
      end
      if (rsp_valid === 1'b1 && v_first < 0) v_first = cyc;
      if (rsp_valid === 1'b1 && rsp_ready)
        rsp_q.push_back('{rsp_id, rsp_data, rsp_flags, rsp_err, v_first - m_acc});
      if (g >= 0) begin
        m_busy  = 1;
        m_id    = (g == 1);
        m_rr    = (g == 0);
        m_a     = (g == 1) ? req1_a   : req0_a;
        m_b     = (g == 1) ? req1_b   : req0_b;
        m_fun   = (g == 1) ? req1_fun : req0_fun;
        m_err   = (m_fun == 4'hF) || (m_fun == 4'h3 && m_b == 0);
        m_legal = !m_err;
        m_data  = m_err ? '0 : alu_calc(m_a, m_b, m_fun);
        m_flags = m_err ? '0 : alu_class(m_fun);
        m_acc   = cyc;
        m_due   = cyc + (m_err ? 1 : 3);
        v_first = -1;
        grant_q.push_back(g);
      end else if (exp_v && rsp_ready) begin
        m_busy = 0;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0;
    req0_a = '0; req0_b = '0; req0_fun = '0;
    req1_a = '0; req1_b = '0; req1_fun = '0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_id"}, rsp_id, 0);
    check({tag, "_rsp_data"}, rsp_data, 0);
    check({tag, "_rsp_flags"}, rsp_flags, 0);
    check({tag, "_rsp_err"}, rsp_err, 0);
    check({tag, "_alu_a"}, alu_a, 0);
    check({tag, "_alu_b"}, alu_b, 0);
    check({tag, "_alu_fun"}, alu_fun, 4'hF);
  endtask

  task automatic do_reset();
    rst = 1;
    idle_inputs();
    repeat (2) observe();
    rst = 0;
    check_reset_vals("reset");
    rsp_q.delete();
    grant_q.delete();
  endtask

  task automatic rand_port(output logic v, output logic [DW-1:0] a, output logic [DW-1:0] b,
                           output logic [FW-1:0] f);
    v = ($urandom_range(0, 99) < 60);
    a = DW'($urandom);
    b = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom);
    f = FW'($urandom);
  endtask

  initial begin
    rst = 1; rsp_ready = 0;
    idle_inputs();
    do_reset();

    // Single add from requester 0.
    rsp_ready = 1;
    req0_valid = 1; req0_a = 16'h0005; req0_b = 16'h0003; req0_fun = 4'h0;
    observe();
    idle_inputs();
    repeat (4) observe();
    check("add_count", rsp_q.size(), 1);
    if (rsp_q.size() > 0) begin
      check("add_lat", rsp_q[0].lat, 3);
      check("add_data", rsp_q[0].data, 16'h0008);
      check("add_flags", rsp_q[0].flags, 4'b1000);
      check("add_id", rsp_q[0].id, 0);
      check("add_err", rsp_q[0].err, 0);
    end

    // Conflict straight out of reset: requester 0 first, then 1.
    do_reset();
    rsp_ready = 1;
    req0_valid = 1; req0_a = 16'h00AA; req0_b = 16'h00AA; req0_fun = 4'hA;
    req1_valid = 1; req1_a = 16'h00AA; req1_b = 16'h00AA; req1_fun = 4'hA;
    for (int k = 0; k < 20 && rsp_q.size() < 2; k++) begin
      observe();
      foreach (grant_q[i]) begin
        if (grant_q[i] == 0) req0_valid = 0;
        if (grant_q[i] == 1) req1_valid = 0;
      end
    end
    idle_inputs();
    check("rr_count", rsp_q.size(), 2);
    if (rsp_q.size() == 2) begin
      check("rr_first_id", rsp_q[0].id, 0);
      check("rr_second_id", rsp_q[1].id, 1);
      check("rr_first_data", rsp_q[0].data, 16'h0001);
      check("rr_second_data", rsp_q[1].data, 16'h0001);
      check("rr_first_flags", rsp_q[0].flags, 4'b0010);
      check("rr_second_flags", rsp_q[1].flags, 4'b0010);
    end

    // Divide by zero from requester 1 is rejected without touching the ALU.
    rsp_q.delete();
    req1_valid = 1; req1_a = 16'h0010; req1_b = 16'h0000; req1_fun = 4'h3;
    observe();
    idle_inputs();
    check("div0_alu_fun", alu_fun, 4'hF);
    repeat (3) observe();
    check("div0_count", rsp_q.size(), 1);
    if (rsp_q.size() > 0) begin
      check("div0_lat", rsp_q[0].lat, 1);
      check("div0_err", rsp_q[0].err, 1);
      check("div0_data", rsp_q[0].data, 0);
      check("div0_flags", rsp_q[0].flags, 0);
      check("div0_id", rsp_q[0].id, 1);
    end

    // Shift with back-pressure, then a request during the RESP exit cycle.
    rsp_q.delete();
    rsp_ready = 0;
    req0_valid = 1; req0_a = 16'h8001; req0_b = 16'h0001; req0_fun = 4'hE;
    observe();
    idle_inputs();
    repeat (8) observe();
    check("bp_held_valid", rsp_valid, 1);
    check("bp_held_data", rsp_data, 16'h0002);
    check("bp_held_flags", rsp_flags, 4'b0001);
    rsp_ready = 1;
    req1_valid = 1; req1_a = 16'h0003; req1_b = 16'h0004; req1_fun = 4'h2;
    check("exit_no_ready1", req1_ready, 0);
    observe();
    check("after_exit_valid", rsp_valid, 0);
    check("after_exit_alu_fun", alu_fun, 4'hF);
    observe();
    idle_inputs();
    repeat (4) observe();
    check("bp_count", rsp_q.size(), 2);
    if (rsp_q.size() == 2) begin
      check("bp_data", rsp_q[0].data, 16'h0002);
      check("mul_data", rsp_q[1].data, 16'h000C);
      check("mul_id", rsp_q[1].id, 1);
    end

    // Reset during WAIT discards the operation.
    rsp_q.delete();
    req0_valid = 1; req0_a = 16'h0001; req0_b = 16'h0002; req0_fun = 4'h0;
    observe();
    idle_inputs();
    observe();
    rst = 1;
    observe();
    rst = 0;
    check_reset_vals("midrst");
    repeat (6) observe();
    check("midrst_no_rsp", rsp_q.size(), 0);

    // Continuous traffic on both ports alternates grants.
    do_reset();
    rsp_ready = 1;
    for (int k = 0; k < 100 && grant_q.size() < 8; k++) begin
      rand_port(req0_valid, req0_a, req0_b, req0_fun);
      rand_port(req1_valid, req1_a, req1_b, req1_fun);
      req0_valid = 1; req1_valid = 1;
      observe();
    end
    idle_inputs();
    repeat (5) observe();
    check("alt_count", grant_q.size(), 8);
    foreach (grant_q[i]) check("alt_grant", grant_q[i], i % 2);

    // Randomized traffic with occasional resets and back-pressure.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      rand_port(req0_valid, req0_a, req0_b, req0_fun);
      rand_port(req1_valid, req1_a, req1_b, req1_fun);
      rsp_ready = ($urandom_range(0, 1) == 1);
      rst = ($urandom_range(0, 199) == 0);
      observe();
    end
    rst = 0;
    rsp_ready = 1;
    idle_inputs();
    repeat (6) observe();
    check("drain_idle_valid", rsp_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DW, 16, operand/result width; SHALL match the shared ALU datapath width.
REQ-002 Parameter FW, 4, function-code width.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req0_valid / req1_valid  input  1  requester n has an operation pending.
REQ-006 req0_ready / req1_ready  output  1  arbiter accepts requester n this cycle.
REQ-007 req0_a, req0_b, req1_a, req1_b  input  DW  operands.
REQ-008 req0_fun / req1_fun  input  FW  ALU function code.
REQ-009 alu_a, alu_b  output  DW  operands to shared ALU.
REQ-010 alu_fun  output  FW  function code to shared ALU.
REQ-011 alu_out  input  DW  registered ALU result, valid one clk after alu_fun/operands.
REQ-012 alu_flags  input  4  {ARITH,LOGIC,CMP,SHIFT}, combinational from alu_fun.
REQ-013 rsp_valid  output  1  response available.
REQ-014 rsp_ready  input  1  consumer takes response.
REQ-015 rsp_id  output  1  requester owning response.
REQ-016 rsp_data  output  DW  result.
REQ-017 rsp_flags  output  4  class flags captured for the operation.
REQ-018 rsp_err  output  1  operation rejected (illegal code or divide by zero).

Function
REQ-019 FSM states SHALL be IDLE, EXEC, WAIT, RESP; exactly one active.
REQ-020 In IDLE, alu_fun SHALL be 4'b1111 and alu_a/alu_b SHALL be 0.
REQ-021 In IDLE, at most one reqN_ready SHALL be high; grant to the single valid requester, or on conflict to the requester not served last (round-robin pointer).
REQ-022 Acceptance (reqN_valid && reqN_ready) SHALL register a, b, fun, id and flip the round-robin pointer to the other requester.
REQ-023 reqN_ready SHALL be 0 in EXEC, WAIT, RESP; no queuing.
REQ-024 Accepted fun 4'b1111, or fun 4'b0011 with b==0, SHALL go IDLE->RESP with rsp_data=0, rsp_flags=0, rsp_err=1; ALU not driven.
REQ-025 Otherwise IDLE->EXEC; in EXEC, alu_a/alu_b/alu_fun SHALL carry the latched operation and alu_flags SHALL be captured at end of EXEC.
REQ-026 EXEC->WAIT unconditionally; alu_fun/operands held in WAIT; alu_out captured at end of WAIT; WAIT->RESP.
REQ-027 Latency: acceptance at cycle t -> rsp_valid first high at t+3 (legal op) or t+1 (rejected op).
REQ-028 In RESP, rsp_valid=1 and rsp_id/data/flags/err SHALL stay stable until rsp_ready=1; RESP->IDLE on the cycle rsp_ready=1.
REQ-029 A new request SHALL NOT be accepted in the cycle RESP exits; earliest acceptance is the following IDLE cycle.
REQ-030 Requester valid dropped before grant SHALL be ignored; no response issued.
REQ-031 Result width SHALL be DW; multiply truncation is the ALU's, passed unchanged.

Reset
REQ-032 rst=1 SHALL force IDLE, round-robin pointer to requester 0, all outputs to: req*_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_flags=0, rsp_err=0, alu_a=alu_b=0, alu_fun=4'b1111.
REQ-033 rst asserted mid-operation (EXEC/WAIT/RESP) SHALL discard the operation; no response after rst deasserts.
REQ-034 First cycle after rst deasserts SHALL be IDLE with grant priority to requester 0.

Verification
REQ-035 req0: a=16'h0005, b=16'h0003, fun=0000 -> rsp_valid at t+3, rsp_data=16'h0008, rsp_flags=4'b1000, rsp_id=0, rsp_err=0.
REQ-036 req0 and req1 both valid from reset, both fun=1010, a=b=16'h00AA -> req0 served first, then req1; both rsp_data=16'h0001, flags=4'b0010.
REQ-037 req1: fun=0011, a=16'h0010, b=0 -> rsp_valid at t+1, rsp_err=1, rsp_data=0, flags=0; ALU fun stays 1111.
REQ-038 req0: fun=1110, a=16'h8001, rsp_ready held 0 for 5 cycles -> rsp_data=16'h0002, flags=4'b0001 stable throughout; IDLE the cycle after rsp_ready=1.
REQ-039 Assert rst during WAIT -> rsp_valid never rises for that op; all outputs at REQ-032 values next cycle.
REQ-040 Continuous requests on both ports for 8 operations -> grants strictly alternate 0,1,0,1...
